// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: state encoding,
// light bit positions and default phase timing.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN,
        MAIN_YELLOW,
        SIDE_GREEN,
        SIDE_YELLOW,
        FLASH
    } state_t;

    localparam int GREEN_BIT  = 0;
    localparam int YELLOW_BIT = 1;
    localparam int RED_BIT    = 2;

    localparam logic [2:0] LIGHT_G   = 3'(1 << GREEN_BIT);
    localparam logic [2:0] LIGHT_Y   = 3'(1 << YELLOW_BIT);
    localparam logic [2:0] LIGHT_R   = 3'(1 << RED_BIT);
    localparam logic [2:0] LIGHT_OFF = 3'b000;

    localparam int DEF_GREEN_INIT  = 14;
    localparam int DEF_YELLOW_INIT = 2;
    localparam int DEF_RED_INIT    = 17;
    localparam int DEF_MIN_GREEN   = 5;
    localparam int DEF_CNT_WIDTH   = 5;

endpackage

// File: rtl/light_counter.sv
// Phase down-counter: loads a phase length on a one-hot init strobe,
// decrements on enable and saturates at zero.
module light_counter
    import traffic_pkg::*;
#(
    parameter int pGREEN_INIT_VAL  = DEF_GREEN_INIT,
    parameter int pYELLOW_INIT_VAL = DEF_YELLOW_INIT,
    parameter int pRED_INIT_VAL    = DEF_RED_INIT,
    parameter int pCNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [2:0]            init,
    output logic [pCNT_WIDTH-1:0] cnt_out,
    output logic                  last
);

    localparam logic [pCNT_WIDTH-1:0] GREEN_LOAD  = pCNT_WIDTH'(pGREEN_INIT_VAL);
    localparam logic [pCNT_WIDTH-1:0] YELLOW_LOAD = pCNT_WIDTH'(pYELLOW_INIT_VAL);
    localparam logic [pCNT_WIDTH-1:0] RED_LOAD    = pCNT_WIDTH'(pRED_INIT_VAL);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_out <= YELLOW_LOAD;
        end else if (init[RED_BIT]) begin
            cnt_out <= RED_LOAD;
        end else if (init[YELLOW_BIT]) begin
            cnt_out <= YELLOW_LOAD;
        end else if (init[GREEN_BIT]) begin
            cnt_out <= GREEN_LOAD;
        end else if (en && cnt_out != '0) begin
            cnt_out <= cnt_out - 1'b1;
        end
    end

    assign last = (cnt_out == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way junction controller with pedestrian early exit from main green
// and a night flashing-yellow mode.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int pGREEN_INIT_VAL  = DEF_GREEN_INIT,
    parameter int pYELLOW_INIT_VAL = DEF_YELLOW_INIT,
    parameter int pRED_INIT_VAL    = DEF_RED_INIT,
    parameter int pMIN_GREEN       = DEF_MIN_GREEN,
    parameter int pCNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  ped_req,
    input  logic                  night,
    output logic [2:0]            main_light,
    output logic [2:0]            side_light,
    output logic                  ped_walk,
    output logic [pCNT_WIDTH-1:0] cnt_out
);

    // Remaining-count threshold at or below which a pending pedestrian may cut green short.
    localparam logic [pCNT_WIDTH-1:0] EARLY_EXIT_CNT = pCNT_WIDTH'(pGREEN_INIT_VAL - pMIN_GREEN);

    state_t     state, next_state;
    logic       blink, next_blink;
    logic       ped_pending;
    logic [2:0] init;
    logic       en;
    logic       last;

    light_counter #(
        .pGREEN_INIT_VAL  (pGREEN_INIT_VAL),
        .pYELLOW_INIT_VAL (pYELLOW_INIT_VAL),
        .pRED_INIT_VAL    (pRED_INIT_VAL),
        .pCNT_WIDTH       (pCNT_WIDTH)
    ) u_light_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .init    (init),
        .cnt_out (cnt_out),
        .last    (last)
    );

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        next_blink = blink;
        init       = '0;
        en         = tick && (state != FLASH);

        if (night) begin
            if (state != FLASH) begin
                next_state = FLASH;
                next_blink = 1'b1;
            end else if (tick) begin
                next_blink = ~blink;
            end
        end else begin
            case (state)
                MAIN_GREEN:
                    if (tick && (last || (ped_pending && cnt_out <= EARLY_EXIT_CNT)))
                        next_state = MAIN_YELLOW;
                MAIN_YELLOW: if (tick && last) next_state = SIDE_GREEN;
                SIDE_GREEN:  if (tick && last) next_state = SIDE_YELLOW;
                SIDE_YELLOW: if (tick && last) next_state = MAIN_GREEN;
                FLASH:       next_state = SIDE_YELLOW;
                default:     next_state = SIDE_YELLOW;
            endcase
        end

        if (next_state != state) begin
            case (next_state)
                MAIN_GREEN, SIDE_GREEN:   init[GREEN_BIT]  = 1'b1;
                MAIN_YELLOW, SIDE_YELLOW: init[YELLOW_BIT] = 1'b1;
                default:                  init             = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SIDE_YELLOW;
            blink       <= 1'b0;
            ped_pending <= 1'b0;
            ped_walk    <= 1'b0;
            main_light  <= LIGHT_R;
            side_light  <= LIGHT_Y;
        end else begin
            state <= next_state;
            blink <= next_blink;

            // A request in the cycle of entering side green is kept for the next cycle.
            if (night) begin
                ped_pending <= 1'b0;
            end else if (ped_req && state != FLASH) begin
                ped_pending <= 1'b1;
            end else if (next_state == SIDE_GREEN && state != SIDE_GREEN) begin
                ped_pending <= 1'b0;
            end

            if (next_state == SIDE_GREEN)
                ped_walk <= (state == SIDE_GREEN) ? ped_walk : ped_pending;
            else
                ped_walk <= 1'b0;

            case (next_state)
                MAIN_GREEN:  begin main_light <= LIGHT_G; side_light <= LIGHT_R; end
                MAIN_YELLOW: begin main_light <= LIGHT_Y; side_light <= LIGHT_R; end
                SIDE_GREEN:  begin main_light <= LIGHT_R; side_light <= LIGHT_G; end
                SIDE_YELLOW: begin main_light <= LIGHT_R; side_light <= LIGHT_Y; end
                default: begin
                    main_light <= next_blink ? LIGHT_Y : LIGHT_OFF;
                    side_light <= next_blink ? LIGHT_Y : LIGHT_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: phase lengths, pedestrian early
// exit, night flash mode and asynchronous reset, with default parameters.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       night = 1'b0;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       ped_walk;
    logic [4:0] cnt_out;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] O = 3'b000;

    traffic_light_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .ped_req    (ped_req),
        .night      (night),
        .main_light (main_light),
        .side_light (side_light),
        .ped_walk   (ped_walk),
        .cnt_out    (cnt_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", tag, actual, expected);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] exp_main,
                                 input logic [2:0] exp_side, input int exp_cnt,
                                 input logic exp_walk);
        check({tag, ".main"}, 32'(main_light), 32'(exp_main));
        check({tag, ".side"}, 32'(side_light), 32'(exp_side));
        check({tag, ".cnt"},  32'(cnt_out),    32'(exp_cnt));
        check({tag, ".walk"}, 32'(ped_walk),   32'(exp_walk));
    endtask

    // One clock cycle with the given inputs set at the preceding falling edge.
    task automatic cyc(input logic t, input logic p, input logic n);
        @(negedge clk);
        tick    = t;
        ped_req = p;
        night   = n;
        @(posedge clk);
        #1;
        tick    = 1'b0;
        ped_req = 1'b0;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset_hold", R, Y, 2, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Leave the reset yellow phase into main green.
        ticks(2);
        check_outputs("sy_count_down", R, Y, 0, 1'b0);
        ticks(1);
        check_outputs("first_main_green", G, R, 14, 1'b0);

        // Full-length phases without pedestrians; zero holds without tick.
        ticks(14);
        check_outputs("mg_at_zero", G, R, 0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
        check_outputs("mg_zero_hold", G, R, 0, 1'b0);
        ticks(1);
        check_outputs("mg_to_my_15", Y, R, 2, 1'b0);
        ticks(2);
        check_outputs("my_before_end", Y, R, 0, 1'b0);
        ticks(1);
        check_outputs("side_green_no_ped", R, G, 14, 1'b0);
        ticks(15);
        check_outputs("side_yellow", R, Y, 2, 1'b0);
        ticks(3);
        check_outputs("back_to_mg", G, R, 14, 1'b0);

        // Pedestrian request at 12: early exit on the tick where cnt is 9.
        ticks(2);
        check_outputs("mg_at_12", G, R, 12, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(3);
        check_outputs("mg_at_9_ped", G, R, 9, 1'b0);
        ticks(1);
        check_outputs("early_exit", Y, R, 2, 1'b0);
        ticks(3);
        check_outputs("sg_walk_entry", R, G, 14, 1'b1);
        ticks(7);
        check_outputs("sg_walk_mid", R, G, 7, 1'b1);

        // Night mode mid side green: flash with frozen counter.
        cyc(1'b0, 1'b0, 1'b1);
        check_outputs("flash_entry", Y, Y, 7, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        check_outputs("flash_off", O, O, 7, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        check_outputs("flash_on", Y, Y, 7, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check_outputs("flash_no_tick", Y, Y, 7, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        check_outputs("flash_off2", O, O, 7, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check_outputs("flash_exit", R, Y, 2, 1'b0);
        ticks(3);
        check_outputs("post_flash_mg", G, R, 14, 1'b0);

        // Asynchronous reset mid green clears a pending request.
        ticks(7);
        check_outputs("mg_at_7", G, R, 7, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_reset", R, Y, 2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(3);
        check_outputs("rst_release_mg", G, R, 14, 1'b0);
        ticks(5);
        check_outputs("no_stale_ped", G, R, 9, 1'b0);
        ticks(9);
        check_outputs("mg_full_after_rst", G, R, 0, 1'b0);
        ticks(1);
        check_outputs("my_after_rst", Y, R, 2, 1'b0);

        // Night and pedestrian together: night wins and the request is dropped.
        cyc(1'b0, 1'b1, 1'b1);
        check_outputs("night_ped_flash", Y, Y, 2, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check_outputs("night_ped_exit", R, Y, 2, 1'b0);
        ticks(3);
        check_outputs("night_ped_mg", G, R, 14, 1'b0);
        ticks(5);
        check_outputs("night_ped_no_early", G, R, 9, 1'b0);
        ticks(10);
        check_outputs("night_ped_my", Y, R, 2, 1'b0);
        ticks(3);
        check_outputs("night_ped_sg", R, G, 14, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
